// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
// Shared constants and state encodings for the serial program loader.
//   SYNC_BYTE  : frame start marker
//   RAM_ADDR_W : address width of the 8K x 16 program RAM
//   ld_state_t : frame FSM states in uart_loader
//   rx_state_t : bit-level states in uart_rx
// ---------------------------------------------------------------------------
package soc_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         RAM_ADDR_W = 13;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LENH,
        LD_LENL,
        LD_DATAH,
        LD_DATAL,
        LD_CSUM,
        LD_DONE,
        LD_ERROR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// ---------------------------------------------------------------------------
// uart_loader_if
// RAM write port driven by the loader.
//   we   : write strobe, one cycle per word
//   addr : word address
//   din  : write data
// master = loader side, slave = RAM side.
// ---------------------------------------------------------------------------
interface uart_loader_if #(
    parameter int ADDR_W = soc_pkg::RAM_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       din;

    modport master (output we, addr, din);
    modport slave  (input  we, addr, din);
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection at
// mid-bit, LSB-first data sampling every DIV cycles, stop-bit check.
//   CLK, I_RESET_N : clock, synchronous active-low reset
//   I_RX           : asynchronous serial input, idle high
//   rx_data        : received byte, stable while rx_valid is high
//   rx_valid       : 1-cycle pulse, the cycle after a good stop-bit sample
//   rx_frame_err   : 1-cycle pulse, the cycle after a low stop-bit sample
// ---------------------------------------------------------------------------
module uart_rx
    import soc_pkg::*;
#(
    parameter int DIV = 277
) (
    input  logic       CLK,
    input  logic       I_RESET_N,
    input  logic       I_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             valid_n, ferr_n;

    // The shift register is untouched from the last data bit until the next
    // start, so it can be presented directly as the byte.
    assign rx_data = shreg;

    // NOTE: sequential state uses non-blocking assignments only, and the reset
    // is sampled on the clock edge like any other input.
    always_ff @(posedge CLK) begin
        if (!I_RESET_N) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= I_RX;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shreg        <= shreg_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (!rx_sync && rx_prev) state_n = RX_START;
            end
            RX_START: begin
                // Mid-start re-sample: a line back high was only a glitch.
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    valid_n = rx_sync;
                    ferr_n  = !rx_sync;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
// Receives a framed program image (A5, LEN_H, LEN_L, 2N data bytes, CSUM)
// over UART, writes it word by word into the program RAM, and holds the
// core in reset until an image with a matching checksum has been loaded.
//   CLK, I_RESET_N : clock, synchronous active-low reset
//   I_RX           : serial input, idle high
//   ram            : RAM write port (we/addr/din)
//   O_CORE_RESET   : active-high core reset, released after a good load
//   O_BUSY         : high while a frame is being received
//   O_ERR          : sticky error, cleared by the next sync byte
// ---------------------------------------------------------------------------
module uart_loader
    import soc_pkg::*;
#(
    parameter int CLK_HZ = 32000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic         CLK,
    input  logic         I_RESET_N,
    input  logic         I_RX,
    uart_loader_if.master ram,
    output logic         O_CORE_RESET,
    output logic         O_BUSY,
    output logic         O_ERR
);
    localparam int          DIV       = CLK_HZ / BAUD;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    uart_rx #(.DIV(DIV)) u_rx (
        .CLK          (CLK),
        .I_RESET_N    (I_RESET_N),
        .I_RX         (I_RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    ld_state_t         state, state_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [15:0]       din_q, din_n;
    logic [15:0]       remaining, remaining_n;
    logic [7:0]        len_hi, len_hi_n;
    logic [7:0]        hi_byte, hi_byte_n;
    logic [7:0]        csum, csum_n;
    logic              core_reset_n, busy_n, err_n;
    logic [15:0]       len_word;
    logic              in_frame;

    assign len_word = {len_hi, rx_data};
    assign in_frame = (state inside {LD_LENH, LD_LENL, LD_DATAH, LD_DATAL, LD_CSUM});

    assign ram.we   = we_q;
    assign ram.addr = addr_q;
    assign ram.din  = din_q;

    always_ff @(posedge CLK) begin
        if (!I_RESET_N) begin
            state        <= LD_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            remaining    <= '0;
            len_hi       <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            O_CORE_RESET <= 1'b1;
            O_BUSY       <= 1'b0;
            O_ERR        <= 1'b0;
        end else begin
            state        <= state_n;
            we_q         <= we_n;
            addr_q       <= addr_n;
            din_q        <= din_n;
            remaining    <= remaining_n;
            len_hi       <= len_hi_n;
            hi_byte      <= hi_byte_n;
            csum         <= csum_n;
            O_CORE_RESET <= core_reset_n;
            O_BUSY       <= busy_n;
            O_ERR        <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        we_n         = 1'b0;
        // Address advances the cycle after each write strobe.
        addr_n       = we_q ? addr_q + 1'b1 : addr_q;
        din_n        = din_q;
        remaining_n  = remaining;
        len_hi_n     = len_hi;
        hi_byte_n    = hi_byte;
        csum_n       = csum;
        core_reset_n = O_CORE_RESET;
        busy_n       = O_BUSY;
        err_n        = O_ERR;

        if (rx_frame_err && in_frame) begin
            state_n = LD_ERROR;
            err_n   = 1'b1;
            busy_n  = 1'b0;
        end else if (rx_valid) begin
            case (state)
                LD_LENH: begin
                    len_hi_n = rx_data;
                    state_n  = LD_LENL;
                end
                LD_LENL: begin
                    if (len_word == 16'd0) begin
                        state_n = LD_CSUM;
                    end else if ({1'b0, len_word} > MAX_WORDS) begin
                        state_n = LD_ERROR;
                        err_n   = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        remaining_n = len_word;
                        state_n     = LD_DATAH;
                    end
                end
                LD_DATAH: begin
                    hi_byte_n = rx_data;
                    csum_n    = csum + rx_data;
                    state_n   = LD_DATAL;
                end
                LD_DATAL: begin
                    we_n        = 1'b1;
                    din_n       = {hi_byte, rx_data};
                    csum_n      = csum + rx_data;
                    remaining_n = remaining - 1'b1;
                    state_n     = (remaining == 16'd1) ? LD_CSUM : LD_DATAH;
                end
                LD_CSUM: begin
                    busy_n = 1'b0;
                    if (rx_data == csum) begin
                        state_n      = LD_DONE;
                        core_reset_n = 1'b0;
                    end else begin
                        state_n = LD_ERROR;
                        err_n   = 1'b1;
                    end
                end
                default: begin
                    // IDLE, DONE and ERROR all wait for a fresh sync byte.
                    if (rx_data == SYNC_BYTE) begin
                        state_n      = LD_LENH;
                        core_reset_n = 1'b1;
                        busy_n       = 1'b1;
                        err_n        = 1'b0;
                        addr_n       = '0;
                        csum_n       = '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_loader
// Directed frames driven bit-serially into uart_loader. A frame-level model
// (byte buffer + arithmetic) predicts RAM writes and status flags; a compare
// process checks every write strobe and the flags in the quiet gaps between
// bytes. Literal expectations pin the model on each scenario.
// ---------------------------------------------------------------------------
module tb_uart_loader;
    import soc_pkg::*;

    localparam int CLK_HZ    = 1_600_000;
    localparam int BAUD      = 100_000;
    localparam int DIV       = CLK_HZ / BAUD;   // 16
    localparam int ADDR_W    = 13;
    localparam int MAX_WORDS = 1 << ADDR_W;
    localparam int GAP       = 6;

    logic CLK = 1'b0;
    logic I_RESET_N = 1'b0;
    logic I_RX = 1'b1;
    logic O_CORE_RESET, O_BUSY, O_ERR;

    uart_loader_if #(.ADDR_W(ADDR_W)) ram ();

    uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
        .CLK          (CLK),
        .I_RESET_N    (I_RESET_N),
        .I_RX         (I_RX),
        .ram          (ram),
        .O_CORE_RESET (O_CORE_RESET),
        .O_BUSY       (O_BUSY),
        .O_ERR        (O_ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model
    // ------------------------------------------------------------------
    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] fq[$];        // frame bytes after the sync byte
    bit         m_in_frame;
    int         m_n;
    logic       m_err, m_busy, m_cr;

    function automatic void model_reset();
        m_in_frame = 1'b0;
        fq.delete();
        exp_wr.delete();
        m_err  = 1'b0;
        m_busy = 1'b0;
        m_cr   = 1'b1;
    endfunction

    function automatic void model_fail();
        m_in_frame = 1'b0;
        m_err      = 1'b1;
        m_busy     = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        int         k;
        logic [7:0] sum;
        wr_t        w;
        if (!m_in_frame) begin
            if (stop_ok && b == 8'hA5) begin
                m_in_frame = 1'b1;
                fq.delete();
                m_err  = 1'b0;
                m_busy = 1'b1;
                m_cr   = 1'b1;
            end
            return;
        end
        if (!stop_ok) begin
            model_fail();
            return;
        end
        fq.push_back(b);
        k = fq.size();
        if (k == 2) begin
            m_n = int'({fq[0], fq[1]});
            if (m_n > MAX_WORDS) begin
                model_fail();
                return;
            end
        end else if (k >= 4 && (k % 2) == 0 && k <= 2 + 2 * m_n) begin
            w.addr = (k - 4) / 2;
            w.data = {fq[k-2], fq[k-1]};
            exp_wr.push_back(w);
        end
        if (k == 3 + 2 * m_n) begin
            sum = 8'h00;
            for (int i = 2; i < 2 + 2 * m_n; i++) sum += fq[i];
            m_in_frame = 1'b0;
            m_busy     = 1'b0;
            if (sum == b) m_cr  = 1'b0;
            else          m_err = 1'b1;
        end
    endfunction

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    bit          settled = 1'b0;
    int          wr_seen = 0;
    int          last_addr = -1;
    logic [15:0] last_din = '0;

    always @(negedge CLK) begin
        wr_t e;
        if (I_RESET_N) begin
            if (ram.we === 1'b1) begin
                wr_seen++;
                last_addr = int'(ram.addr);
                last_din  = ram.din;
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, no write expected",
                             ram.addr, ram.din);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(ram.addr), 32'(e.addr));
                    check("wr_din", 32'(ram.din), 32'(e.data));
                end
            end
            if (settled) begin
                check("err", 32'(O_ERR), 32'(m_err));
                check("core_reset", 32'(O_CORE_RESET), 32'(m_cr));
                check("busy", 32'(O_BUSY), 32'(m_busy));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        model_byte(b, stop_ok);
        settled = 1'b0;
        @(negedge CLK);
        I_RX = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            I_RX = b[i];
            repeat (DIV) @(negedge CLK);
        end
        I_RX = stop_ok;
        repeat (DIV) @(negedge CLK);
        I_RX = 1'b1;
        settled = 1'b1;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(ram.we), 32'd0);
        check({tag, "_addr"}, 32'(ram.addr), 32'd0);
        check({tag, "_din"}, 32'(ram.din), 32'd0);
        check({tag, "_core_reset"}, 32'(O_CORE_RESET), 32'd1);
        check({tag, "_busy"}, 32'(O_BUSY), 32'd0);
        check({tag, "_err"}, 32'(O_ERR), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    logic [7:0] frame[$];
    int         w0;

    initial begin
        model_reset();
        I_RESET_N = 1'b0;
        I_RX      = 1'b1;
        repeat (4) @(negedge CLK);
        check_reset_values("por");
        I_RESET_N = 1'b1;
        settled   = 1'b1;
        repeat (2 * DIV) @(negedge CLK);

        // Good two-word frame: 0x12+0x34+0xAB+0xCD = 0x1BE -> 0xBE
        w0 = wr_seen;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        send_seq(frame);
        check("t1_writes", 32'(wr_seen - w0), 32'd2);
        check("t1_last_addr", 32'(last_addr), 32'd1);
        check("t1_last_din", 32'(last_din), 32'hABCD);
        check("t1_core_reset", 32'(O_CORE_RESET), 32'd0);
        check("t1_err", 32'(O_ERR), 32'd0);

        // Same payload, wrong checksum: data still written, error raised
        w0 = wr_seen;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
        send_seq(frame);
        check("t2_writes", 32'(wr_seen - w0), 32'd2);
        check("t2_err", 32'(O_ERR), 32'd1);
        check("t2_core_reset", 32'(O_CORE_RESET), 32'd1);
        check("t2_busy", 32'(O_BUSY), 32'd0);

        // Zero-length image releases the core without writes
        w0 = wr_seen;
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(frame);
        check("t3_writes", 32'(wr_seen - w0), 32'd0);
        check("t3_core_reset", 32'(O_CORE_RESET), 32'd0);
        check("t3_err", 32'(O_ERR), 32'd0);

        // Length 0x2001 exceeds 8192 words
        w0 = wr_seen;
        frame = '{8'hA5, 8'h20, 8'h01};
        send_seq(frame);
        check("t3b_writes", 32'(wr_seen - w0), 32'd0);
        check("t3b_err", 32'(O_ERR), 32'd1);
        check("t3b_core_reset", 32'(O_CORE_RESET), 32'd1);
        check("t3b_busy", 32'(O_BUSY), 32'd0);

        // Framing error on second data byte
        w0 = wr_seen;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12};
        send_seq(frame);
        send_byte(8'h34, 1'b0);
        check("t4_writes", 32'(wr_seen - w0), 32'd0);
        check("t4_err", 32'(O_ERR), 32'd1);
        check("t4_busy", 32'(O_BUSY), 32'd0);
        w0 = wr_seen;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        send_seq(frame);
        check("t4_reload_writes", 32'(wr_seen - w0), 32'd2);
        check("t4_reload_err", 32'(O_ERR), 32'd0);
        check("t4_reload_core_reset", 32'(O_CORE_RESET), 32'd0);

        // Short low glitch, then a stray byte, then a sync byte
        w0 = wr_seen;
        @(negedge CLK);
        I_RX = 1'b0;
        repeat (5) @(negedge CLK);
        I_RX = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
        check("t5_glitch_busy", 32'(O_BUSY), 32'd0);
        send_byte(8'h55);
        check("t5_stray_busy", 32'(O_BUSY), 32'd0);
        check("t5_stray_core_reset", 32'(O_CORE_RESET), 32'd0);
        send_byte(8'hA5);
        check("t5_sync_busy", 32'(O_BUSY), 32'd1);
        check("t5_sync_core_reset", 32'(O_CORE_RESET), 32'd1);
        // 0xBE+0xEF = 0x1AD -> 0xAD
        frame = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAD};
        send_seq(frame);
        check("t5_writes", 32'(wr_seen - w0), 32'd1);
        check("t5_last_din", 32'(last_din), 32'hBEEF);
        check("t5_last_addr", 32'(last_addr), 32'd0);
        check("t5_core_reset", 32'(O_CORE_RESET), 32'd0);

        // One-cycle reset in the middle of a payload
        frame = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};
        send_seq(frame);
        check("t6_pre_busy", 32'(O_BUSY), 32'd1);
        check("t6_pre_addr", 32'(ram.addr), 32'd1);
        settled = 1'b0;
        @(negedge CLK);
        I_RESET_N = 1'b0;
        @(negedge CLK);
        check_reset_values("t6_rst");
        model_reset();
        I_RESET_N = 1'b1;
        settled   = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
        // 0x33+0x44+0x55+0x66 = 0x132 -> 0x32
        w0 = wr_seen;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h33, 8'h44, 8'h55, 8'h66, 8'h32};
        send_seq(frame);
        check("t6_writes", 32'(wr_seen - w0), 32'd2);
        check("t6_last_addr", 32'(last_addr), 32'd1);
        check("t6_last_din", 32'(last_din), 32'h5566);
        check("t6_core_reset", 32'(O_CORE_RESET), 32'd0);
        check("t6_err", 32'(O_ERR), 32'd0);

        check("writes_drained", 32'(exp_wr.size()), 32'd0);

        settled = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
